// File: rtl/sc_pointtype_sequencer.sv
// Game-flow controller for one SC_RegPOINTTYPE lane register.
// It starts a game, paces the lane with periodic rotate commands, and handles
// frog collisions (lives), nest arrivals (nests and level) and level-transition
// loads. It also reports lives, level and game-over status to the display
// logic. Every output comes straight from a flop, so the lane register and
// the display see glitch-free control pins.

module sc_pointtype_sequencer #(
  parameter int         SHIFT_PERIOD    = 25000000, // cycles between rotate pulses (>= 2)
  parameter int         CNT_WIDTH       = 25,       // must hold SHIFT_PERIOD-1
  parameter logic [1:0] SHIFT_DIR       = 2'b01,    // 2'b01 rotate left, 2'b10 rotate right
  parameter int         LIVES_INIT      = 3,        // 1..7
  parameter int         NESTS_PER_LEVEL = 4,        // 1..15
  parameter int         HIT_HOLD        = 8         // cycles frozen after a collision (>= 1)
) (
  input  logic       SC_RegPOINTTYPE_CLOCK_50,
  input  logic       SC_RegPOINTTYPE_RESET_InHigh,
  input  logic       start_InLow,
  input  logic       collision_InLow,
  input  logic       nest_InLow,
  output logic       clear_OutLow,
  output logic       load0_OutLow,
  output logic       load1_OutLow,
  output logic [1:0] shiftselection_Out,
  output logic       transition_Out,
  output logic [7:0] transitionDATA_OutBUS,
  output logic [2:0] lives_OutBUS,
  output logic [2:0] level_OutBUS,
  output logic       gameover_Out
);

  // The hold counter only needs to reach HIT_HOLD-1.
  localparam int HOLD_WIDTH = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  localparam logic [CNT_WIDTH-1:0]  PERIOD_LAST = CNT_WIDTH'(SHIFT_PERIOD - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST   = HOLD_WIDTH'(HIT_HOLD - 1);
  localparam logic [2:0]            LIVES_START = 3'(LIVES_INIT);
  localparam logic [3:0]            NESTS_GOAL  = 4'(NESTS_PER_LEVEL);
  localparam logic [2:0]            LEVEL_MAX   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,      // waiting for start, lane held cleared
    INIT,      // one cycle: release clear and load pattern 0
    RUN,       // normal play, periodic rotates
    HIT,       // frozen after a collision
    LEVELUP,   // one cycle: transition load of the new level pattern
    GAMEOVER   // out of lives, lane held cleared
  } stateType;

  stateType                state, stateNext;
  logic [CNT_WIDTH-1:0]    periodCount, periodCountNext;
  logic [HOLD_WIDTH-1:0]   holdCount, holdCountNext;
  logic [2:0]              lives, livesNext;
  logic [2:0]              level, levelNext;
  logic [3:0]              nests, nestsNext;

  // Registered copies of every output pin.
  logic       clearLow, clearLowNext;
  logic       load0Low, load0LowNext;
  logic       load1Low, load1LowNext;
  logic [1:0] shiftSel, shiftSelNext;
  logic       transition, transitionNext;
  logic [7:0] transitionData, transitionDataNext;
  logic       gameover, gameoverNext;

  logic       periodTick;

  // Next-state and next-output decision: outputs are computed for the state
  // being entered so that, once registered, they line up with that state.
  always_comb begin
    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would infer a latch instead of logic.
    stateNext          = state;
    periodCountNext    = periodCount;
    holdCountNext      = holdCount;
    livesNext          = lives;
    levelNext          = level;
    nestsNext          = nests;
    clearLowNext       = 1'b1;
    load0LowNext       = 1'b1;
    load1LowNext       = 1'b1;
    shiftSelNext       = 2'b00;
    transitionNext     = 1'b0;
    transitionDataNext = 8'h00;
    gameoverNext       = 1'b0;
    periodTick         = (periodCount == PERIOD_LAST);

    case (state)
      IDLE, GAMEOVER: begin
        if (!start_InLow) begin
          // Fresh game: lane is released and pattern 0 loaded next cycle.
          stateNext    = INIT;
          livesNext    = LIVES_START;
          levelNext    = 3'd0;
          nestsNext    = 4'd0;
          load0LowNext = 1'b0;
        end else begin
          clearLowNext = 1'b0;
          gameoverNext = (state == GAMEOVER);
        end
      end

      INIT: begin
        stateNext       = RUN;
        periodCountNext = '0;
      end

      RUN: begin
        // The period counter keeps its rhythm even when an event swallows
        // the rotate pulse, so the next tick is still one period away.
        periodCountNext = periodTick ? '0 : periodCount + CNT_WIDTH'(1);

        if (!collision_InLow) begin
          // Collision beats both a nest arrival and a rotate tick.
          stateNext     = HIT;
          holdCountNext = '0;
          if (lives != 3'd0) begin
            livesNext = lives - 3'd1;
          end
        end else if (!nest_InLow) begin
          if (nests + 4'd1 == NESTS_GOAL) begin
            stateNext      = LEVELUP;
            nestsNext      = 4'd0;
            levelNext      = (level == LEVEL_MAX) ? LEVEL_MAX : level + 3'd1;
            transitionNext = 1'b1;
            // A left shift of 8'h01 by 0..7 equals the left rotate.
            transitionDataNext = 8'h01 << levelNext;
          end else begin
            nestsNext    = nests + 4'd1;
            load1LowNext = 1'b0;
          end
        end else if (periodTick) begin
          shiftSelNext = SHIFT_DIR;
        end
      end

      HIT: begin
        if (holdCount == HOLD_LAST) begin
          periodCountNext = '0;
          if (lives != 3'd0) begin
            stateNext = RUN;
          end else begin
            stateNext    = GAMEOVER;
            clearLowNext = 1'b0;
            gameoverNext = 1'b1;
          end
        end else begin
          holdCountNext = holdCount + HOLD_WIDTH'(1);
        end
      end

      LEVELUP: begin
        stateNext       = RUN;
        periodCountNext = '0;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, counters and output pins, all returned to idle values on reset.
  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      state          <= IDLE;
      periodCount    <= '0;
      holdCount      <= '0;
      lives          <= 3'd0;
      level          <= 3'd0;
      nests          <= 4'd0;
      clearLow       <= 1'b0;
      load0Low       <= 1'b1;
      load1Low       <= 1'b1;
      shiftSel       <= 2'b00;
      transition     <= 1'b0;
      transitionData <= 8'h00;
      gameover       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state          <= stateNext;
      periodCount    <= periodCountNext;
      holdCount      <= holdCountNext;
      lives          <= livesNext;
      level          <= levelNext;
      nests          <= nestsNext;
      clearLow       <= clearLowNext;
      load0Low       <= load0LowNext;
      load1Low       <= load1LowNext;
      shiftSel       <= shiftSelNext;
      transition     <= transitionNext;
      transitionData <= transitionDataNext;
      gameover       <= gameoverNext;
    end
  end

  assign clear_OutLow          = clearLow;
  assign load0_OutLow          = load0Low;
  assign load1_OutLow          = load1Low;
  assign shiftselection_Out    = shiftSel;
  assign transition_Out        = transition;
  assign transitionDATA_OutBUS = transitionData;
  assign lives_OutBUS          = lives;
  assign level_OutBUS          = level;
  assign gameover_Out          = gameover;

endmodule

// File: tb/tb_sc_pointtype_sequencer.sv
// Self-checking bench for sc_pointtype_sequencer with a short shift period.
// A behavioural game model tracks what the lane controls must look like; the
// DUT is compared against it on every falling edge, and a directed opening
// pins the model with literal expectations before a long random run.

module tb_sc_pointtype_sequencer;

  localparam int         P   = 4;
  localparam int         HH  = 2;
  localparam int         LI  = 2;
  localparam int         NPL = 2;
  localparam logic [1:0] DIR = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic       startN = 1'b1;
  logic       collN  = 1'b1;
  logic       nestN  = 1'b1;
  logic       clearN, load0N, load1N, trans, over;
  logic [1:0] shiftSel;
  logic [7:0] tData;
  logic [2:0] lives, level;

  int nCompared   = 0;
  int nMismatched = 0;
  bit checking    = 1'b0;

  always #5 clk = ~clk;

  sc_pointtype_sequencer #(
    .SHIFT_PERIOD(P), .CNT_WIDTH(3), .SHIFT_DIR(DIR),
    .LIVES_INIT(LI), .NESTS_PER_LEVEL(NPL), .HIT_HOLD(HH)
  ) dut (
    .SC_RegPOINTTYPE_CLOCK_50(clk),
    .SC_RegPOINTTYPE_RESET_InHigh(rst),
    .start_InLow(startN),
    .collision_InLow(collN),
    .nest_InLow(nestN),
    .clear_OutLow(clearN),
    .load0_OutLow(load0N),
    .load1_OutLow(load1N),
    .shiftselection_Out(shiftSel),
    .transition_Out(trans),
    .transitionDATA_OutBUS(tData),
    .lives_OutBUS(lives),
    .level_OutBUS(level),
    .gameover_Out(over)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  typedef enum {M_IDLE, M_INIT, M_RUN, M_HIT, M_LVL, M_OVER} phase_t;
  phase_t     phase;
  int         mLives, mLevel, mNests, runEdges, hitLeft;
  logic       eClrN, eLd0N, eLd1N, eTrans, eOver;
  logic [1:0] eShift;
  logic [7:0] eTdata;

  task model_reset();
    phase  = M_IDLE; mLives = 0; mLevel = 0; mNests = 0; runEdges = 0; hitLeft = 0;
    eClrN  = 1'b0; eLd0N = 1'b1; eLd1N = 1'b1; eShift = 2'b00;
    eTrans = 1'b0; eTdata = 8'h00; eOver = 1'b0;
  endtask

  // One clock edge of play, using the inputs present at that edge.
  task model_step();
    bit st, co, ne;
    st = !startN; co = !collN; ne = !nestN;
    eClrN = 1'b1; eLd0N = 1'b1; eLd1N = 1'b1; eShift = 2'b00;
    eTrans = 1'b0; eTdata = 8'h00; eOver = 1'b0;
    case (phase)
      M_IDLE, M_OVER: begin
        if (st) begin
          phase = M_INIT; mLives = LI; mLevel = 0; mNests = 0; eLd0N = 1'b0;
        end else begin
          eClrN = 1'b0; eOver = (phase == M_OVER);
        end
      end
      M_INIT: begin phase = M_RUN; runEdges = 0; end
      M_RUN: begin
        runEdges++;
        if (co) begin
          if (mLives > 0) mLives--;
          phase = M_HIT; hitLeft = HH;
        end else if (ne) begin
          mNests++;
          if (mNests == NPL) begin
            mNests = 0;
            if (mLevel < 7) mLevel++;
            phase = M_LVL; eTrans = 1'b1; eTdata = 8'(1 << mLevel);
          end else begin
            eLd1N = 1'b0;
          end
        end else if (runEdges % P == 0) begin
          eShift = DIR;
        end
      end
      M_HIT: begin
        hitLeft--;
        if (hitLeft == 0) begin
          if (mLives > 0) begin
            phase = M_RUN; runEdges = 0;
          end else begin
            phase = M_OVER; eClrN = 1'b0; eOver = 1'b1;
          end
        end
      end
      M_LVL: begin phase = M_RUN; runEdges = 0; end
      default: phase = M_IDLE;
    endcase
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("cycle_outputs",
            {11'd0, clearN, load0N, load1N, shiftSel, trans, tData, lives, level, over},
            {11'd0, eClrN, eLd0N, eLd1N, eShift, eTrans, eTdata, 3'(mLives), 3'(mLevel), eOver});
    end
  end

  // Drive inputs, take one rising edge, advance the model, settle 2 ns.
  task automatic cycle(input bit s, input bit c, input bit n);
    startN = s; collN = c; nestN = n;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #2;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    checking = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset values.
    check("rst_clear", clearN, 0);
    check("rst_load0", load0N, 1);
    check("rst_shift", shiftSel, 0);
    check("rst_lives", lives, 0);
    check("rst_over",  over, 0);
    idle(1);

    // Start: one load0 pulse, then one rotate every 4 cycles.
    cycle(1'b0, 1'b1, 1'b1);
    check("init_load0", load0N, 0);
    check("init_clear", clearN, 1);
    check("init_lives", lives, 2);
    idle(1);
    check("run_load0_end", load0N, 1);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      check("run_shift", shiftSel, (k % 4 == 0) ? 2'b01 : 2'b00);
    end

    // Collision and nest together: collision wins.
    cycle(1'b1, 1'b0, 1'b0);
    check("both_lives", lives, 1);
    check("both_load1", load1N, 1);
    check("both_shift", shiftSel, 0);
    idle(1);
    check("hit_shift", shiftSel, 0);
    idle(1);
    check("hit_exit_over", over, 0);

    // First nest gives load1 (so the simultaneous nest was not counted).
    cycle(1'b1, 1'b1, 1'b0);
    check("nest1_load1", load1N, 0);
    cycle(1'b1, 1'b1, 1'b0);
    check("nest2_trans", trans, 1);
    check("nest2_tdata", tData, 8'h02);
    check("nest2_level", level, 1);
    check("nest2_load1", load1N, 1);
    idle(1);
    check("lvl_trans_end", trans, 0);

    // Nest on the tick cycle: load1 only, next tick one full period later.
    idle(3);
    cycle(1'b1, 1'b1, 1'b0);
    check("tick_nest_load1", load1N, 0);
    check("tick_nest_shift", shiftSel, 0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check("after_drop_shift", shiftSel, (k == 4) ? 2'b01 : 2'b00);
    end

    // Last life lost, game over after the hold.
    cycle(1'b1, 1'b0, 1'b1);
    check("last_hit_lives", lives, 0);
    idle(1);
    check("last_hit_over", over, 0);
    idle(1);
    check("gameover_flag", over, 1);
    check("gameover_clear", clearN, 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("gameover_ignore", lives, 0);

    // Restart, then reset in the middle of HIT.
    cycle(1'b0, 1'b1, 1'b1);
    check("restart_lives", lives, 2);
    idle(3);
    cycle(1'b1, 1'b0, 1'b1);
    check("pre_rst_lives", lives, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_clear", clearN, 0);
    check("midrst_lives", lives, 0);
    check("midrst_level", level, 0);
    idle(1);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b1);
    check("post_rst_lives", lives, 2);

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b1;
        model_reset();
        idle(1);
        rst = 1'b0;
      end else begin
        cycle($urandom_range(0, 7) != 0,
              $urandom_range(0, 39) != 0,
              $urandom_range(0, 4) != 0);
      end
    end

    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
